conv_stream_packer: RTL and testbench
=====================================

Name: conv_stream_packer

Overview:
- Output-side consumer of the 3x3 convolution core. Accepts the core's free-running pxl_out/valid pixel stream, which has no backpressure.
- Buffers pixels in a small FIFO and presents them as an AXI4-Stream master towards the DMA S2MM channel.
- Generates tlast on the final convolved pixel of each frame, plus frame-done and overflow status.

Parameters:
- DATA_W, 32, pixel word width ({pad[7:0], R, G, B}).
- M, 480, input frame rows.
- N, 640, input frame columns.
- K, 3, kernel size. Output pixels per frame PIX_TOTAL = (M-K+1)*(N-K+1), which is 304964 at defaults.
- CNT_W, 20, pixel counter width. Must satisfy 2^CNT_W > PIX_TOTAL.
- DEPTH, 16, FIFO entries. Power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- Start  in  1  frame enable. Low clears frame state.
- in_data  in  DATA_W  pixel from conv core.
- in_valid  in  1  in_data valid this cycle.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last pixel of frame.
- overflow  out  1  sticky: a pixel was dropped.
- frame_done  out  1  one-cycle pulse after the tlast beat is accepted.
- level  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: one clock (clk) and an asynchronous active-low reset (reset_n); polarity and synchronicity are fixed. While reset_n is low, the following are held at 0: m_axis_tvalid, m_axis_tlast, m_axis_tdata, overflow, frame_done, level, both FIFO pointers, and the pixel counter. Reset asserted mid-frame discards all buffered data immediately.
- Push condition: push = Start && in_valid && (!full || pop).
- Pop condition: pop = m_axis_tvalid && m_axis_tready.
- FIFO entry format: {last_tag, in_data}, DATA_W+1 bits.
- Output timing: first-word-fall-through.
  - m_axis_tvalid = !empty.
  - m_axis_tdata and m_axis_tlast come from the head entry.
  - tdata and tlast read 0 when empty.
  - A push into an empty FIFO at edge t makes tvalid visible after edge t, so latency is 1 cycle.
- Pixel counter (pix_cnt):
  - Increments on every cycle with Start && in_valid, whether or not the pixel is accepted.
  - last_tag = (pix_cnt == PIX_TOTAL-1).
  - On that pixel, pix_cnt wraps to 0.
  - This keeps tlast frame-aligned even after a drop.
- Drop: Start && in_valid && full && !pop means the pixel is discarded and overflow is set. overflow stays set until reset_n or Start low. If the dropped pixel carried last_tag, no tlast is emitted for that frame; overflow flags it.
- Simultaneous push and pop:
  - When full: legal. Level is unchanged and no overflow occurs.
  - When empty: impossible, because pop requires !empty.
- level: +1 on push only, -1 on pop only, unchanged otherwise.
- frame_done: registered. It is 1 in the cycle after an edge where pop && head last_tag.
- Start low (synchronous):
  - pix_cnt is cleared to 0 and overflow is cleared.
  - in_valid is ignored.
  - FIFO contents are retained and continue to drain normally.
- AXIS rules:
  - Once m_axis_tvalid is high, tdata and tlast are held stable until the beat is accepted.
  - tvalid never depends combinationally on tready.
- Pointers: ADDR_W = log2(DEPTH). Each pointer is ADDR_W+1 bits wide with a wrap bit. full and empty are derived from the pointers and registered level; there is no separate counter mismatch.

Decomposition:
- Shared package conv_pkg holds:
  - DATA_W, M, N, K;
  - the derived PIX_TOTAL constant;
  - CNT_W;
  - a clog2 helper function.
- The conv core and this block both use the package.
- One sub-module, sync_fifo_fwft, parameterised by width and depth. It provides push, pop, head data, full, empty and level.
- Counter, tagging, overflow and frame_done logic live in conv_stream_packer.

Test Plan:
All scenarios use M=5, N=6, K=3 (so PIX_TOTAL=12) and DEPTH=4.
1. Reset: hold reset_n=0 and drive random inputs -> all outputs stay 0. Releasing reset with idle inputs -> outputs remain 0.
2. Start=1, tready=1, 12 consecutive in_valid with data 0..11 -> 12 beats, each 1 cycle after its input, in order. tlast only on data 11. frame_done pulses once, the cycle after that beat. overflow=0.
3. Backpressure with tready=0, pushing data 0..4:
   - After 4 pushes -> level=4, tvalid=1, tdata=0.
   - The 5th push (data 4) -> dropped, overflow=1, level stays 4.
   - Then tready=1 -> beats 0,1,2,3, then tvalid=0.
4. FIFO full and tready=1 while in_valid continues every cycle -> level stays 4, no overflow, output order preserved.
5. Two back-to-back frames, 24 pixels (data 0..23) with tready=1 -> tlast on data 11 and data 23. frame_done pulses twice.
6. Start dropped after 5 pixels, then raised again with a fresh 12-pixel frame -> overflow cleared, buffered pixels drained. tlast falls on the 12th pixel after the restart.
7. reset_n pulsed low mid-frame with level=3 -> outputs are 0 asynchronously, without waiting for a clock edge. After release, a new 12-pixel frame produces correct tlast.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the 3x3 convolution datapath and its
// stream-side consumers.
package conv_pkg;

  localparam int DATA_W = 32;   // {pad[7:0], R, G, B}
  localparam int M      = 480;  // input frame rows
  localparam int N      = 640;  // input frame columns
  localparam int K      = 3;    // kernel size
  localparam int CNT_W  = 20;   // wide enough to index every output pixel

  // Number of valid convolution outputs in one frame.
  function automatic int pix_total(input int rows, input int cols, input int ksz);
    return (rows - ksz + 1) * (cols - ksz + 1);
  endfunction

  localparam int PIX_TOTAL = pix_total(M, N, K);

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rdata whenever the FIFO is not empty; rdata reads 0 when empty.
module sync_fifo_fwft
  import conv_pkg::clog2;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int ADDR_W = clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;

  // Pointers carry a wrap bit: equal pointers mean empty, equal addresses
  // with opposite wrap bits mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign rdata = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

  // Storage write.
  // NOTE: the storage array has no reset; its contents are never observed
  // until written, because rdata is forced to 0 while empty. Resetting it
  // would only add a reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
  end

  // Pointer and occupancy update; a simultaneous push and pop leaves level unchanged.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      case ({push, pop})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/conv_stream_packer.sv
// Turns the convolution core's free-running pixel stream into an AXI4-Stream
// master: buffers pixels, tags the last pixel of each frame for tlast, and
// reports frame completion and dropped pixels.
module conv_stream_packer
  import conv_pkg::clog2;
  import conv_pkg::pix_total;
#(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int M      = conv_pkg::M,
  parameter int N      = conv_pkg::N,
  parameter int K      = conv_pkg::K,
  parameter int CNT_W  = conv_pkg::CNT_W,
  parameter int DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  Start,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  overflow,
  output logic                  frame_done,
  output logic [clog2(DEPTH):0] level
);

  localparam int               PIX_TOTAL = pix_total(M, N, K);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PIX_TOTAL - 1);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic             pix_seen;
  logic             last_tag;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] pix_cnt;
  entry_t           wr_entry;
  entry_t           head;

  // A pixel is counted whenever it arrives in an enabled frame, even if the
  // FIFO cannot take it, so tlast stays aligned to the frame after a drop.
  assign pix_seen = Start && in_valid;
  assign last_tag = (pix_cnt == LAST_IDX);

  assign pop  = m_axis_tvalid && m_axis_tready;
  assign push = pix_seen && (!full || pop);

  assign wr_entry = '{last: last_tag, data: in_data};

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = head.data;
  assign m_axis_tlast  = head.last;

  sync_fifo_fwft #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_entry),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Frame pixel counter: wraps on the last pixel, cleared while Start is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt <= '0;
    end else if (!Start) begin
      pix_cnt <= '0;
    end else if (in_valid) begin
      pix_cnt <= last_tag ? '0 : pix_cnt + CNT_W'(1);
    end
  end

  // Sticky drop flag: set when an enabled pixel finds the FIFO full with no pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (!Start) begin
      overflow <= 1'b0;
    end else if (pix_seen && !push) begin
      overflow <= 1'b1;
    end
  end

  // One-cycle pulse after the tlast beat is accepted downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && head.last;
    end
  end

endmodule

// File: tb/tb_conv_stream_packer.sv
// Self-checking bench for conv_stream_packer with a 5x6 frame, 3x3 kernel
// (12 output pixels per frame) and a 4-entry FIFO. A queue-based model of
// the stream rules predicts every output each cycle.
module tb_conv_stream_packer;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 4;
  localparam int PIX_TOTAL = 12;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } ent_t;

  logic              clk;
  logic              reset_n;
  logic              Start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              overflow;
  logic              frame_done;
  logic [2:0]        level;

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t mq[$];
  int   pix_idx;
  logic ovf_m;
  logic fd_m;

  // Observed accepted beats and frame_done pulses
  ent_t dut_beats[$];
  int   fd_seen;

  conv_stream_packer #(
    .DATA_W (DATA_W),
    .M      (5),
    .N      (6),
    .K      (3),
    .CNT_W  (20),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .Start         (Start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .frame_done    (frame_done),
    .level         (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    mq.delete();
    pix_idx = 0;
    ovf_m   = 1'b0;
    fd_m    = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle against the
  // model, then advance the model across the rising edge.
  task automatic step(input logic st, input logic iv, input logic [31:0] d, input logic rdy);
    logic        pop_m, fire, tag, push_m;
    logic        exp_valid, exp_last;
    logic [31:0] exp_data;
    ent_t        e;
    Start = st; in_valid = iv; in_data = d; m_axis_tready = rdy;
    @(negedge clk);
    exp_valid = (mq.size() != 0);
    exp_data  = exp_valid ? mq[0].data : 32'd0;
    exp_last  = exp_valid ? mq[0].last : 1'b0;
    checks++;
    if (m_axis_tvalid !== exp_valid) begin
      errors++; $display("FAIL tvalid t=%0t got=%b exp=%b", $time, m_axis_tvalid, exp_valid);
    end
    checks++;
    if (m_axis_tdata !== exp_data) begin
      errors++; $display("FAIL tdata t=%0t got=%0d exp=%0d", $time, m_axis_tdata, exp_data);
    end
    checks++;
    if (m_axis_tlast !== exp_last) begin
      errors++; $display("FAIL tlast t=%0t got=%b exp=%b", $time, m_axis_tlast, exp_last);
    end
    checks++;
    if (level !== 3'(mq.size())) begin
      errors++; $display("FAIL level t=%0t got=%0d exp=%0d", $time, level, mq.size());
    end
    checks++;
    if (overflow !== ovf_m) begin
      errors++; $display("FAIL overflow t=%0t got=%b exp=%b", $time, overflow, ovf_m);
    end
    checks++;
    if (frame_done !== fd_m) begin
      errors++; $display("FAIL frame_done t=%0t got=%b exp=%b", $time, frame_done, fd_m);
    end
    if (m_axis_tvalid === 1'b1 && rdy) dut_beats.push_back('{last: m_axis_tlast, data: m_axis_tdata});
    if (frame_done === 1'b1) fd_seen++;
    // Model update from the stream rules
    pop_m  = (mq.size() != 0) && rdy;
    fire   = st && iv;
    tag    = fire && (pix_idx == PIX_TOTAL - 1);
    push_m = fire && ((mq.size() < DEPTH) || pop_m);
    fd_m   = 1'b0;
    if (pop_m) begin
      e    = mq.pop_front();
      fd_m = e.last;
    end
    if (push_m) mq.push_back('{last: tag, data: d});
    if (!st) begin
      pix_idx = 0;
      ovf_m   = 1'b0;
    end else if (iv) begin
      pix_idx = tag ? 0 : pix_idx + 1;
      if (!push_m) ovf_m = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Start = 1'($urandom); in_valid = 1'($urandom);
      in_data = $urandom; m_axis_tready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, overflow, frame_done, level} !== '0) begin
        errors++;
        $display("FAIL reset_hold got valid=%b last=%b data=%0d ovf=%b fd=%b level=%0d exp all 0",
                 m_axis_tvalid, m_axis_tlast, m_axis_tdata, overflow, frame_done, level);
      end
    end
    @(posedge clk); #1;
    Start = 1'b0; in_valid = 1'b0; in_data = '0; m_axis_tready = 1'b0;
    reset_n = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_single_frame();
    drain(2);
    dut_beats.delete(); fd_seen = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 32'(i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    checks++;
    if (dut_beats.size() != 12) begin
      errors++; $display("FAIL single_beats got=%0d exp=12", dut_beats.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (dut_beats[i] !== '{last: (i == 11), data: 32'(i)}) begin
          errors++; $display("FAIL single_order idx=%0d got=%0d/%b exp=%0d/%b",
                             i, dut_beats[i].data, dut_beats[i].last, i, (i == 11));
        end
      end
    end
    checks++;
    if (fd_seen != 1) begin
      errors++; $display("FAIL single_frame_done got=%0d pulses exp=1", fd_seen);
    end
  endtask

  task automatic test_backpressure();
    drain(6);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(i), 1'b0);
    checks++;
    if (level !== 3'd4 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd0) begin
      errors++; $display("FAIL bp_full got level=%0d valid=%b data=%0d exp 4/1/0",
                         level, m_axis_tvalid, m_axis_tdata);
    end
    step(1'b1, 1'b1, 32'd4, 1'b0);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL bp_drop got level=%0d ovf=%b exp 4/1", level, overflow);
    end
    dut_beats.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    checks++;
    if (dut_beats.size() != 4 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL bp_drain got beats=%0d valid=%b exp 4/0", dut_beats.size(), m_axis_tvalid);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_beats[i].data !== 32'(i)) begin
          errors++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, dut_beats[i].data, i);
        end
      end
    end
  endtask

  task automatic test_full_throughput();
    drain(6);
    dut_beats.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(100 + i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 32'(200 + i), 1'b1);
      checks++;
      if (level !== 3'd4 || overflow !== 1'b0) begin
        errors++; $display("FAIL thru_level idx=%0d got level=%0d ovf=%b exp 4/0", i, level, overflow);
      end
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    checks++;
    if (dut_beats.size() != 12) begin
      errors++; $display("FAIL thru_beats got=%0d exp=12", dut_beats.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (dut_beats[i].data !== ((i < 4) ? 32'(100 + i) : 32'(196 + i))) begin
          errors++; $display("FAIL thru_order idx=%0d got=%0d", i, dut_beats[i].data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    drain(6);
    dut_beats.delete(); fd_seen = 0;
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 32'(i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    checks++;
    if (dut_beats.size() != 24) begin
      errors++; $display("FAIL b2b_beats got=%0d exp=24", dut_beats.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (dut_beats[i] !== '{last: (i == 11 || i == 23), data: 32'(i)}) begin
          errors++; $display("FAIL b2b_beat idx=%0d got=%0d/%b", i, dut_beats[i].data, dut_beats[i].last);
        end
      end
    end
    checks++;
    if (fd_seen != 2) begin
      errors++; $display("FAIL b2b_frame_done got=%0d pulses exp=2", fd_seen);
    end
  endtask

  task automatic test_start_restart();
    drain(6);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'(i), 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL restart_ovf_set got=%b exp=1", overflow);
    end
    step(1'b0, 1'b1, $urandom, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL restart_ovf_clear got=%b exp=0", overflow);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, $urandom, 1'b1);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL restart_drained got valid=%b exp=0", m_axis_tvalid);
    end
    dut_beats.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 32'(50 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    checks++;
    if (dut_beats.size() != 12 || dut_beats[11] !== '{last: 1'b1, data: 32'd61}) begin
      errors++; $display("FAIL restart_tlast got beats=%0d", dut_beats.size());
    end
  endtask

  task automatic test_async_reset();
    drain(6);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'(i), 1'b0);
    checks++;
    if (level !== 3'd3) begin
      errors++; $display("FAIL areset_pre got level=%0d exp=3", level);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, overflow, frame_done, level} !== '0) begin
      errors++; $display("FAIL areset_async got valid=%b data=%0d level=%0d exp all 0",
                         m_axis_tvalid, m_axis_tdata, level);
    end
    @(posedge clk); #1;
    Start = 1'b0; in_valid = 1'b0; m_axis_tready = 1'b0;
    reset_n = 1'b1;
    model_clear();
    dut_beats.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 32'(300 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    checks++;
    if (dut_beats.size() != 12 || dut_beats[11] !== '{last: 1'b1, data: 32'd311}
        || dut_beats[10].last !== 1'b0) begin
      errors++; $display("FAIL areset_frame got beats=%0d", dut_beats.size());
    end
  endtask

  task automatic test_random();
    drain(6);
    for (int i = 0; i < 400; i++)
      step(1'(($urandom % 16) != 0), 1'(($urandom % 4) != 0), $urandom, 1'(($urandom % 3) != 0));
    drain(6);
  endtask

  initial begin
    reset_n = 1'b0; Start = 1'b0; in_valid = 1'b0; in_data = '0; m_axis_tready = 1'b0;
    fd_seen = 0;
    model_clear();
    test_reset();
    test_single_frame();
    test_backpressure();
    test_full_throughput();
    test_back_to_back();
    test_start_restart();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
